// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way cache data array.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    function automatic int calc_set_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int calc_word_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // A single-way cache still needs a 1-bit way select field.
    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_data_array_nway_if.sv
// Bus between the cache controller / memory side (master) and the data array (slave).
interface cache_data_array_nway_if #(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int WORDS = 8,
    parameter int DW    = 16
);
    import cache_pkg::*;

    localparam int SET_W  = calc_set_w(SETS);
    localparam int WORD_W = calc_word_w(WORDS);
    localparam int WAY_W  = calc_way_w(WAYS);

    logic                 rd_en;
    logic [SET_W-1:0]     rd_set;
    logic [WORD_W-1:0]    rd_word;
    logic                 rd_valid;
    logic [WAYS*DW-1:0]   rd_data;

    logic                 wr_en;
    logic                 wr_ready;
    logic [WAY_W-1:0]     wr_way;
    logic [SET_W-1:0]     wr_set;
    logic [WORD_W-1:0]    wr_word;
    logic [DW-1:0]        wr_data;

    logic                 fill_start;
    logic [WAY_W-1:0]     fill_way;
    logic [SET_W-1:0]     fill_set;
    logic                 fill_valid;
    logic [DW-1:0]        fill_data;
    logic                 fill_busy;
    logic                 fill_done;

    modport master (
        output rd_en, rd_set, rd_word,
        output wr_en, wr_way, wr_set, wr_word, wr_data,
        output fill_start, fill_way, fill_set, fill_valid, fill_data,
        input  rd_valid, rd_data, wr_ready, fill_busy, fill_done
    );

    modport slave (
        input  rd_en, rd_set, rd_word,
        input  wr_en, wr_way, wr_set, wr_word, wr_data,
        input  fill_start, fill_way, fill_set, fill_valid, fill_data,
        output rd_valid, rd_data, wr_ready, fill_busy, fill_done
    );

endinterface

// File: rtl/cache_data_way.sv
// Storage for one cache way: SETS x WORDS words, one write port and a
// registered read port that returns the word being written in the same cycle.
module cache_data_way
    import cache_pkg::*;
#(
    parameter  int SETS   = 64,
    parameter  int WORDS  = 8,
    parameter  int DW     = 16,
    localparam int SET_W  = calc_set_w(SETS),
    localparam int WORD_W = calc_word_w(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SET_W-1:0]  wset,
    input  logic [WORD_W-1:0] wword,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [SET_W-1:0]  rset,
    input  logic [WORD_W-1:0] rword,
    output logic [DW-1:0]     rdata
);

    localparam int ADDR_W = SET_W + WORD_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              bypass;

    assign waddr  = {wset, wword};
    assign raddr  = {rset, rword};
    assign bypass = we && (waddr == raddr);

    // Whole array clears on reset so a fresh cache never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= bypass ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/cache_data_array_nway.sv
// N-way set-associative cache data store with parallel way reads, CPU word
// writes and a block-fill sequencer that streams a block into one way.
module cache_data_array_nway
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int WORDS = 8,
    parameter int DW    = 16
) (
    input logic                   clk,
    input logic                   rst,
    cache_data_array_nway_if.slave bus
);

    localparam int SET_W  = calc_set_w(SETS);
    localparam int WORD_W = calc_word_w(WORDS);
    localparam int WAY_W  = calc_way_w(WAYS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

    fill_state_e       state;
    fill_state_e       state_next;
    logic [WORD_W-1:0] cnt;
    logic [WAY_W-1:0]  fill_way_q;
    logic [SET_W-1:0]  fill_set_q;

    logic              fill_start_ok;
    logic              fill_we;
    logic              fill_busy;
    logic              fill_done;
    logic              cpu_we;
    logic              rd_valid_q;

    logic              mem_we;
    logic [WAY_W-1:0]  mem_way;
    logic [SET_W-1:0]  mem_set;
    logic [WORD_W-1:0] mem_word;
    logic [DW-1:0]     mem_data;
    logic [WAYS*DW-1:0] rd_data_all;

    assign fill_start_ok = bus.fill_start && (int'(bus.fill_way) < WAYS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fill_start_ok) state_next = FILL;
            FILL:    if (bus.fill_valid && (cnt == LAST_WORD)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fill_busy = 1'b0;
        fill_done = 1'b0;
        fill_we   = 1'b0;
        case (state)
            FILL: begin
                fill_busy = 1'b1;
                fill_we   = bus.fill_valid;
            end
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

    // Target is latched at start so the controller may change fill_way/fill_set mid-fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            fill_way_q <= '0;
            fill_set_q <= '0;
        end else if ((state == IDLE) && fill_start_ok) begin
            cnt        <= '0;
            fill_way_q <= bus.fill_way;
            fill_set_q <= bus.fill_set;
        end else if (fill_we) begin
            cnt <= (cnt == LAST_WORD) ? '0 : cnt + WORD_W'(1);
        end
    end

    assign cpu_we = bus.wr_en && !fill_busy && (int'(bus.wr_way) < WAYS);

    // Single shared write port; the fill stream wins over the CPU.
    always_comb begin
        if (fill_we) begin
            mem_we   = 1'b1;
            mem_way  = fill_way_q;
            mem_set  = fill_set_q;
            mem_word = cnt;
            mem_data = bus.fill_data;
        end else begin
            mem_we   = cpu_we;
            mem_way  = bus.wr_way;
            mem_set  = bus.wr_set;
            mem_word = bus.wr_word;
            mem_data = bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic way_we;
        assign way_we = mem_we && (mem_way == WAY_W'(w));

        cache_data_way #(
            .SETS  (SETS),
            .WORDS (WORDS),
            .DW    (DW)
        ) u_way (
            .clk   (clk),
            .rst   (rst),
            .we    (way_we),
            .wset  (mem_set),
            .wword (mem_word),
            .wdata (mem_data),
            .re    (bus.rd_en),
            .rset  (bus.rd_set),
            .rword (bus.rd_word),
            .rdata (rd_data_all[w*DW +: DW])
        );
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_all;
    assign bus.wr_ready  = !fill_busy;
    assign bus.fill_busy = fill_busy;
    assign bus.fill_done = fill_done;

endmodule

// File: tb/tb_cache_data_array_nway.sv
// Directed and randomized checks of cache_data_array_nway against a
// word-array model of the cache contents.
module tb_cache_data_array_nway;

    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int WORDS  = 8;
    localparam int DW     = 16;
    localparam int SET_W  = $clog2(SETS);
    localparam int WORD_W = $clog2(WORDS);
    localparam int WAY_W  = 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0]      model [WAYS][SETS][WORDS];
    logic [WAYS*DW-1:0] last_row;

    cache_data_array_nway_if #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .DW(DW)) bus ();

    cache_data_array_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_en      = 1'b0;
        bus.rd_set     = '0;
        bus.rd_word    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_way     = '0;
        bus.wr_set     = '0;
        bus.wr_word    = '0;
        bus.wr_data    = '0;
        bus.fill_start = 1'b0;
        bus.fill_way   = '0;
        bus.fill_set   = '0;
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
    endtask

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                for (int k = 0; k < WORDS; k++)
                    model[w][s][k] = '0;
    endtask

    function automatic logic [WAYS*DW-1:0] row(input int s, input int wd);
        logic [WAYS*DW-1:0] r;
        for (int w = 0; w < WAYS; w++) r[w*DW +: DW] = model[w][s][wd];
        return r;
    endfunction

    task automatic read_check(input string tag, input int s, input int wd);
        bus.rd_en   = 1'b1;
        bus.rd_set  = SET_W'(s);
        bus.rd_word = WORD_W'(wd);
        tick();
        bus.rd_en = 1'b0;
        last_row  = row(s, wd);
        check_output({tag, "_valid"}, 64'(bus.rd_valid), 64'(1));
        check_output({tag, "_data"}, 64'(bus.rd_data), 64'(last_row));
    endtask

    task automatic apply_stimulus(input int way, input int s, input int wd, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_way  = WAY_W'(way);
        bus.wr_set  = SET_W'(s);
        bus.wr_word = WORD_W'(wd);
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        model[way][s][wd] = data;
    endtask

    // Streams one block; stall_mask bit c holds fill_valid low in cycle c.
    // poke drives a CPU write and a second fill_start into the busy period.
    task automatic do_fill(input string tag, input int way, input int s,
                           input logic [DW-1:0] words [WORDS], input int stall_mask, input bit poke);
        int  i;
        int  c;
        bit  stall;
        bus.fill_start = 1'b1;
        bus.fill_way   = WAY_W'(way);
        bus.fill_set   = SET_W'(s);
        tick();
        bus.fill_start = 1'b0;
        bus.wr_en      = 1'b0;
        check_output({tag, "_busy_start"}, 64'(bus.fill_busy), 64'(1));
        check_output({tag, "_ready_start"}, 64'(bus.wr_ready), 64'(0));
        i = 0;
        c = 0;
        while (i < WORDS && c < 64) begin
            stall = (c < 32) && stall_mask[c];
            if (poke && c == 1) begin
                check_output({tag, "_ready_busy"}, 64'(bus.wr_ready), 64'(0));
                bus.wr_en      = 1'b1;
                bus.wr_way     = WAY_W'(WAYS - 1 - way);
                bus.wr_set     = SET_W'(s);
                bus.wr_word    = WORD_W'(2);
                bus.wr_data    = 16'hDEAD;
                bus.fill_start = 1'b1;
                bus.fill_way   = WAY_W'(WAYS - 1 - way);
                bus.fill_set   = SET_W'(s ^ 1);
            end
            bus.fill_valid = !stall;
            bus.fill_data  = stall ? DW'($urandom) : words[i];
            tick();
            bus.wr_en      = 1'b0;
            bus.fill_start = 1'b0;
            if (!stall) begin
                model[way][s][i] = words[i];
                i++;
            end
            c++;
            if (i < WORDS) begin
                check_output($sformatf("%s_busy_c%0d", tag, c), 64'(bus.fill_busy), 64'(1));
                check_output($sformatf("%s_done_c%0d", tag, c), 64'(bus.fill_done), 64'(0));
            end
        end
        bus.fill_valid = 1'b0;
        check_output({tag, "_done_pulse"}, 64'(bus.fill_done), 64'(1));
        check_output({tag, "_busy_end"}, 64'(bus.fill_busy), 64'(0));
        check_output({tag, "_ready_end"}, 64'(bus.wr_ready), 64'(1));
        tick();
        check_output({tag, "_done_once"}, 64'(bus.fill_done), 64'(0));
        check_output({tag, "_busy_idle"}, 64'(bus.fill_busy), 64'(0));
    endtask

    initial begin
        logic [DW-1:0]      blk [WORDS];
        logic [WAYS*DW-1:0] exp_row;
        int                 rs, rw, ws, ww, wy;
        bit                 do_rd, do_wr;
        logic [DW-1:0]      wd;

        rst = 1'b1;
        idle_inputs();
        model_clear();
        last_row = '0;
        #12;
        check_output("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_output("reset_rd_data", 64'(bus.rd_data), 64'(0));
        check_output("reset_busy", 64'(bus.fill_busy), 64'(0));
        check_output("reset_done", 64'(bus.fill_done), 64'(0));
        check_output("reset_ready", 64'(bus.wr_ready), 64'(1));
        tick();
        rst = 1'b0;

        read_check("t1", 0, 0);

        apply_stimulus(1, 5, 3, 16'hBEEF);
        read_check("t2", 5, 3);
        check_output("t2_way1", 64'(bus.rd_data[DW +: DW]), 64'(16'hBEEF));
        check_output("t2_way0", 64'(bus.rd_data[0 +: DW]), 64'(0));
        tick();
        check_output("t2_rd_idle", 64'(bus.rd_valid), 64'(0));
        check_output("t2_rd_hold", 64'(bus.rd_data), 64'(last_row));

        for (int i = 0; i < WORDS; i++) blk[i] = DW'(16'h1000 + i);
        do_fill("t3", 0, 63, blk, 32'b0010_0100, 1'b0);
        for (int i = 0; i < WORDS; i++) read_check($sformatf("t3_rb%0d", i), 63, i);

        for (int i = 0; i < WORDS; i++) blk[i] = DW'($urandom);
        do_fill("t4", 1, 5, blk, 32'b0000_1000, 1'b1);
        for (int i = 0; i < WORDS; i++) read_check($sformatf("t4_rb%0d", i), 5, i);
        read_check("t4_other_set", 4, 0);

        bus.rd_en   = 1'b1;
        bus.rd_set  = SET_W'(2);
        bus.rd_word = WORD_W'(7);
        apply_stimulus(0, 2, 7, 16'h00AA);
        bus.rd_en = 1'b0;
        last_row  = row(2, 7);
        check_output("t5_valid", 64'(bus.rd_valid), 64'(1));
        check_output("t5_way0", 64'(bus.rd_data[0 +: DW]), 64'(16'h00AA));
        check_output("t5_row", 64'(bus.rd_data), 64'(last_row));

        bus.wr_en   = 1'b1;
        bus.wr_way  = WAY_W'(0);
        bus.wr_set  = SET_W'(10);
        bus.wr_word = WORD_W'(4);
        bus.wr_data = 16'h5A5A;
        model[0][10][4] = 16'h5A5A;
        for (int i = 0; i < WORDS; i++) blk[i] = DW'($urandom);
        do_fill("tsame", 1, 10, blk, 0, 1'b0);
        read_check("tsame_rb", 10, 4);

        for (int n = 0; n < 60; n++) begin
            do_rd = ($urandom_range(0, 3) != 0);
            do_wr = ($urandom_range(0, 1) != 0);
            ws = $urandom_range(0, 3);
            ww = $urandom_range(0, WORDS - 1);
            wy = $urandom_range(0, WAYS - 1);
            wd = DW'($urandom);
            if ($urandom_range(0, 1) != 0) begin
                rs = ws;
                rw = ww;
            end else begin
                rs = $urandom_range(0, 3);
                rw = $urandom_range(0, WORDS - 1);
            end
            bus.rd_en   = do_rd;
            bus.rd_set  = SET_W'(rs);
            bus.rd_word = WORD_W'(rw);
            bus.wr_en   = do_wr;
            bus.wr_way  = WAY_W'(wy);
            bus.wr_set  = SET_W'(ws);
            bus.wr_word = WORD_W'(ww);
            bus.wr_data = wd;
            tick();
            if (do_wr) model[wy][ws][ww] = wd;
            if (do_rd) begin
                exp_row  = row(rs, rw);
                last_row = exp_row;
                check_output($sformatf("rnd%0d_valid", n), 64'(bus.rd_valid), 64'(1));
            end else begin
                check_output($sformatf("rnd%0d_valid", n), 64'(bus.rd_valid), 64'(0));
            end
            check_output($sformatf("rnd%0d_data", n), 64'(bus.rd_data), 64'(last_row));
        end
        idle_inputs();

        bus.fill_start = 1'b1;
        bus.fill_way   = WAY_W'(0);
        bus.fill_set   = SET_W'(20);
        tick();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = DW'(16'h7700 + i);
            tick();
        end
        bus.fill_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_output("t6_busy_async", 64'(bus.fill_busy), 64'(0));
        check_output("t6_done_async", 64'(bus.fill_done), 64'(0));
        check_output("t6_rd_data_async", 64'(bus.rd_data), 64'(0));
        check_output("t6_ready_async", 64'(bus.wr_ready), 64'(1));
        model_clear();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("t6_no_done%0d", i), 64'(bus.fill_done), 64'(0));
            check_output($sformatf("t6_no_busy%0d", i), 64'(bus.fill_busy), 64'(0));
        end
        for (int i = 0; i < 4; i++) read_check($sformatf("t6_clr%0d", i), 20, i);
        read_check("t6_clr_beef", 5, 3);
        for (int i = 0; i < WORDS; i++) blk[i] = DW'($urandom);
        do_fill("t6_refill", 1, 20, blk, 32'b0001_0000, 1'b0);
        for (int i = 0; i < WORDS; i++) read_check($sformatf("t6_rb%0d", i), 20, i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
